// File: rtl/uart_rx_frontend_if.sv
// Byte stream from the UART receiver to the solution core, plus receiver status.
// The receiver drives the master modport and the core drives the slave modport.
interface uart_rx_frontend_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    modport master (
        output data, valid, busy, frame_err, overrun, parity_err,
        input  ready
    );

    modport slave (
        input  data, valid, busy, frame_err, overrun, parity_err,
        output ready
    );
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver with a synchronizer, mid-bit sampling, a one-byte holding register and error pulses.
// Define UART_RX_PARITY_EN to switch to 8E1 with a parity check.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 217,
    parameter int HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               rx_i,
    uart_rx_frontend_if.master out_if
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          bit_end;
    logic          deliver;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          perr_q, perr_d;
`endif

    // The line is idle high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif

        if (valid_q && out_if.ready) valid_d = 1'b0;

        case (state_q)
            // In START the counter equals the number of cycles since rx_s first read low.
            ST_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                    cnt_d   = CW'(1);
                end
            end
            ST_START: begin
                if (cnt_q == CW'(HALF_BIT)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end else begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{shift_q, par_q}) perr_d = 1'b1;
                        else                   deliver = 1'b1;
`else
                        deliver = 1'b1;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A byte consumed on the delivery edge frees the holding register for the new one.
        if (deliver) begin
            if (!valid_q || out_if.ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign out_if.data      = data_q;
    assign out_if.valid     = valid_q;
    assign out_if.busy      = (state_q != ST_IDLE);
    assign out_if.frame_err = ferr_q;
    assign out_if.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign out_if.parity_err = perr_q;
`else
    assign out_if.parity_err = 1'b0;
`endif

endmodule
